// File: rtl/rc4_pkg.sv
// Shared types and constants for the arcfour cracker and its message reader.
package rc4_pkg;

  localparam int NUM_CORES          = 51;
  localparam int LOG_NUM_CORES      = 8;
  localparam int MESSAGE_LENGTH     = 32;
  localparam int MESSAGE_LOG_LENGTH = 5;
  localparam int RAM_WIDTH          = 8;

  // Sized forms of the limits so compares stay width-matched.
  localparam logic [LOG_NUM_CORES-1:0]      CORE_LIMIT = LOG_NUM_CORES'(NUM_CORES);
  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_IDX   = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  localparam logic [RAM_WIDTH-1:0] ASCII_LO    = 8'h61;
  localparam logic [RAM_WIDTH-1:0] ASCII_HI    = 8'h7A;
  localparam logic [RAM_WIDTH-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } state_t;

  // Plaintext alphabet: lowercase letters and space.
  function automatic logic is_plain_char(input logic [RAM_WIDTH-1:0] c);
    return ((c >= ASCII_LO) && (c <= ASCII_HI)) || (c == ASCII_SPACE);
  endfunction

endpackage

// File: rtl/message_reader_char_checker.sv
// Sticky flag raised when a sampled byte falls outside the plaintext alphabet.
module char_checker
  import rc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [RAM_WIDTH-1:0] data,
  output logic                 char_err
);

  // Clear on a new message, otherwise accumulate bad-byte hits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_err <= 1'b0;
    end else if (clear) begin
      char_err <= 1'b0;
    end else if (sample && !is_plain_char(data)) begin
      char_err <= 1'b1;
    end
  end

endmodule

// File: rtl/message_reader.sv
// Reads the winning core's A RAM back byte by byte and streams it out on a
// valid/ready byte interface, flagging any non-plaintext byte.
module message_reader
  import rc4_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  input  logic [LOG_NUM_CORES-1:0]      core_sel,
  output logic [LOG_NUM_CORES-1:0]      rd_core,
  output logic [MESSAGE_LOG_LENGTH-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0]          rd_data,
  output logic [RAM_WIDTH-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done,
  output logic                          char_err,
  output logic                          range_err
);

  state_t                          state;
  state_t                          state_next;
  logic [MESSAGE_LOG_LENGTH-1:0]   idx;
  logic [LOG_NUM_CORES-1:0]        core_q;
  logic                            start;
  logic                            range_bad;
  logic                            handshake;

  // A trigger only counts while not busy; busy-time triggers are dropped.
  assign start     = trigger && ((state == IDLE) || (state == DONE));
  assign range_bad = (core_sel >= CORE_LIMIT);
  assign handshake = (state == SEND) && m_ready;

  // Flow-control and status outputs decode straight from the state register.
  assign m_valid = (state == SEND);
  assign busy    = (state == REQ) || (state == WAIT) || (state == SEND);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: REQ -> WAIT -> SEND per byte, SEND waits for the sink.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (trigger) state_next = range_bad ? DONE : REQ;
      REQ:        state_next = WAIT;
      WAIT:       state_next = SEND;
      SEND:       if (m_ready) state_next = m_last ? DONE : REQ;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: read address is loaded on entry to REQ so the RAM samples it at
  // the end of REQ and its q is captured at the end of WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      core_q    <= '0;
      rd_core   <= '0;
      rd_addr   <= '0;
      m_data    <= '0;
      m_last    <= 1'b0;
      range_err <= 1'b0;
    end else if (start) begin
      core_q    <= core_sel;
      idx       <= '0;
      range_err <= range_bad;
      if (!range_bad) begin
        rd_core <= core_sel;
        rd_addr <= '0;
      end
    end else if (state == WAIT) begin
      m_data <= rd_data;
      m_last <= (idx == LAST_IDX);
    end else if (handshake && !m_last) begin
      idx     <= idx + 1'b1;
      rd_addr <= idx + 1'b1;
      rd_core <= core_q;
    end
  end

  // Alphabet check on each byte as it is captured.
  char_checker u_char_checker (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .sample   (state == WAIT),
    .data     (rd_data),
    .char_err (char_err)
  );

endmodule

// File: tb/tb_message_reader.sv
// Directed bench for message_reader with a RAM model and byte scoreboard.
module tb_message_reader;
  import rc4_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset = 1'b0;
  logic                          trigger = 1'b0;
  logic [LOG_NUM_CORES-1:0]      core_sel = '0;
  logic [LOG_NUM_CORES-1:0]      rd_core;
  logic [MESSAGE_LOG_LENGTH-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]          rd_data = '0;
  logic [RAM_WIDTH-1:0]          m_data;
  logic                          m_valid;
  logic                          m_ready = 1'b1;
  logic                          m_last;
  logic                          busy;
  logic                          done;
  logic                          char_err;
  logic                          range_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:63][0:31];
  logic [7:0] exp_q [$];

  message_reader dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .core_sel  (core_sel),
    .rd_core   (rd_core),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .char_err  (char_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM behind the read mux.
  always @(posedge clk) rd_data <= ram[rd_core[5:0]][rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_msg(input int core, input string s);
    for (int i = 0; i < 32; i++) ram[core][i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  task automatic push_msg(input int core);
    for (int i = 0; i < 32; i++) exp_q.push_back(ram[core][i]);
  endtask

  // Leaves the bench at the negedge just after the trigger edge E0.
  task automatic pulse_trigger(input logic [7:0] sel);
    @(negedge clk);
    trigger  = 1'b1;
    core_sel = sel;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Runs one message from the negedge after E0; n counts edges since E0.
  task automatic stream(input bit toggle, input int exp_first, input int exp_done,
                        input int exp_err_at, input int inject_at, input int reset_at);
    int n = 0;
    int nbytes = 0;
    int first = -1;
    int err_at = -1;
    bit stalled = 0;
    bit err_fell = 0;
    bit finished = 0;
    logic [7:0] held_d = '0;
    logic held_l = 1'b0;
    logic [7:0] exp_b;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (n < 400 && !finished) begin
      m_ready = toggle ? pat[n % 4] : 1'b1;
      trigger = (n == inject_at);
      if (n == inject_at) core_sel = 8'd3;
      if (inject_at >= 0 && n == inject_at + 1) check("ignored_trigger_core", rd_core, 7);
      if (n == reset_at) begin
        reset = 1'b0;
        #1;
        check("rst_rd_core", rd_core, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_char_err", char_err, 0);
        check("rst_range_err", range_err, 0);
        finished = 1;
      end else begin
        if (char_err && err_at < 0) err_at = n;
        if (err_at >= 0 && !char_err) err_fell = 1;
        if (stalled) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, held_d);
          check("stall_last", m_last, held_l);
        end
        stalled = 0;
        if (m_valid) begin
          if (first < 0) first = n;
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              check("extra_byte", 1, 0);
            end else begin
              exp_b = exp_q.pop_front();
              check("byte", m_data, exp_b);
              check("last_flag", m_last, exp_q.size() == 0);
              nbytes++;
            end
          end else begin
            stalled = 1;
            held_d  = m_data;
            held_l  = m_last;
          end
        end
        if (done) begin
          finished = 1;
          check("bytes_before_done", nbytes, 32);
          if (exp_done >= 0) check("done_edge", n, exp_done);
        end else begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    end
    trigger = 1'b0;
    m_ready = 1'b1;
    if (reset_at < 0) check("done_seen", done, 1);
    if (exp_first >= 0) check("first_valid_edge", first, exp_first);
    if (exp_err_at >= 0) begin
      check("char_err_edge", err_at, exp_err_at);
      check("char_err_sticky", err_fell, 0);
      check("char_err_final", char_err, 1);
    end
  endtask

  initial begin
    for (int c = 0; c < 64; c++) load_msg(c, "");
    load_msg(7, "attack at dawn");
    load_msg(3, "the quick brown fox");

    #12;
    check("reset_rd_core", rd_core, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_range_err", range_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: full message, sink always ready.
    push_msg(7);
    pulse_trigger(8'd7);
    check("t1_rd_core", rd_core, 7);
    stream(1'b0, 2, 96, -1, -1, -1);
    check("t1_char_err", char_err, 0);

    // 2: sink toggles 1-0-0-1.
    push_msg(7);
    pulse_trigger(8'd7);
    check("t2_done_cleared", done, 0);
    stream(1'b1, 2, -1, -1, -1, -1);
    check("t2_char_err", char_err, 0);

    // 3: uppercase byte at index 5.
    ram[7][5] = 8'h41;
    push_msg(7);
    pulse_trigger(8'd7);
    check("t3_char_err_cleared", char_err, 0);
    stream(1'b0, 2, 96, 17, -1, -1);
    ram[7][5] = "c";

    // 5: trigger during SEND of byte 10 is ignored, then a restart from DONE.
    push_msg(7);
    pulse_trigger(8'd7);
    check("t5_char_err_cleared", char_err, 0);
    stream(1'b0, 2, 96, -1, 32, -1);
    check("t5_rd_core_kept", rd_core, 7);
    push_msg(3);
    pulse_trigger(8'd3);
    check("t5_restart_core", rd_core, 3);
    check("t5_restart_addr", rd_addr, 0);
    check("t5_restart_done", done, 0);
    check("t5_restart_busy", busy, 1);
    stream(1'b0, 2, 96, -1, -1, -1);

    // 6: reset in WAIT of byte 20.
    push_msg(7);
    pulse_trigger(8'd7);
    stream(1'b0, -1, -1, -1, -1, 61);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_idle_valid", m_valid, 0);
      check("t6_idle_busy", busy, 0);
    end

    // 4: out-of-range core index.
    pulse_trigger(8'd60);
    check("t4_range_err", range_err, 1);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_rd_addr", rd_addr, 0);
    check("t4_rd_core", rd_core, 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_no_valid", m_valid, 0);
      @(negedge clk);
    end
    check("t4_range_err_hold", range_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
